pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Watches decode operands,
//  the execute stage's latched results and memory-stage busy to drive stall_in for
//  fetch/decode/execute and to kill wrong-path work after a taken branch.
//  Stops the machine when the final instruction retires; keeps stall/flush perf counts.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles younger-stage valids are killed after a branch redirect (>=1)
//  CNT_W         32  width of perf counters (saturating)
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      synchronous active-high reset
//  id_valid            in   1      decode holds a valid instruction
//  id_rs1 / id_rs2     in   5 ea   decode source registers
//  id_uses_rs1/_rs2    in   1 ea   decode actually reads that source
//  ex_valid            in   1      execute input_valid (instruction now in execute)
//  ex_rd               in   5      execute rd
//  ex_is_load          in   1      execute: ex_is_memory_address & !memory_addr_is_write
//  ex_write_to_rd      in   1      execute write_to_rd
//  mem_valid           in   1      execute result_is_valid_q
//  mem_is_branch       in   1      execute result_is_branch_addr_q
//  mem_branch_target   in   64     execute result_q
//  mem_busy            in   1      memory stage cannot accept/advance this cycle
//  wb_valid            in   1      writeback holds a valid instruction
//  wb_is_final         in   1      writeback instruction is_final_instruction
//  stall_fd            out  1      hold fetch and decode registers
//  stall_ex            out  1      drives execute stall_in
//  bubble_ex           out  1      force valid=0 into execute latch this cycle
//  kill_fd             out  1      force valid=0 in fetch and decode latches
//  redirect_valid      out  1      one-cycle pulse: fetch must load redirect_pc
//  redirect_pc         out  64     branch target
//  halted              out  1      sticky: final instruction retired
//  stall_count         out  CNT_W  cycles with stall_fd=1 (excluding HALT)
//  flush_count         out  CNT_W  number of redirects issued
// BEHAVIOUR
//  States: RUN, FLUSH, HALT. Reset -> RUN; all outputs 0, counters 0, flush_ctr 0.
//  Priority (high->low): rst > HALT > mem_busy > branch redirect > load-use.
//  HALT: entered the cycle after wb_valid&wb_is_final; stall_fd=stall_ex=1, halted=1,
//   all other outputs 0; exits only on rst. Counters frozen.
//  mem_busy=1 (RUN/FLUSH): stall_fd=stall_ex=1, bubble_ex=0, redirect_valid=0;
//   flush_ctr frozen; a branch seen during busy is deferred until busy drops.
//  Redirect: mem_valid&mem_is_branch&!mem_busy in RUN -> same-cycle (combinational)
//   redirect_valid=1, redirect_pc=mem_branch_target, kill_fd=1, bubble_ex=1;
//   next state FLUSH with flush_ctr=FLUSH_CYCLES-1; flush_count+=1.
//   Branch with mem_valid in FLUSH is ignored (wrong-path, already killed).
//  FLUSH: kill_fd=1, bubble_ex=1 each non-busy cycle; flush_ctr decrements;
//   at 0 return to RUN. FLUSH_CYCLES=1 -> FLUSH state skipped (redirect cycle only).
//  Load-use (RUN, no redirect, no busy): ex_valid&ex_is_load&ex_write_to_rd&ex_rd!=0&
//   id_valid&((id_uses_rs1&id_rs1==ex_rd)|(id_uses_rs2&id_rs2==ex_rd)) ->
//   stall_fd=1, bubble_ex=1, stall_ex=0 for exactly that cycle (load advances; next
//   cycle hazard clears via forwarding). stall_count+=1.
//  Simultaneous redirect+load-use: redirect wins; no stall, stall_count unchanged.
//  stall_count increments every cycle stall_fd=1 outside HALT; both counters saturate
//   at all-ones (no wrap).
//  All control outputs are combinational from state+inputs; state/counters registered.
//  rst mid-FLUSH or in HALT: next cycle RUN, outputs 0, counters cleared.
// TESTING
//  Load x5 in ex, decode uses rs2=x5 -> 1 cycle stall_fd=1,bubble_ex=1,stall_ex=0; stall_count=1.
//  Same with ex_rd=0 or id_uses_rs2=0 -> no stall; stall_count stays 0.
//  Branch at mem, target 0x8000_0040, FLUSH_CYCLES=2 -> redirect pulse 1 cycle,
//   kill_fd/bubble_ex high 2 cycles, flush_count=1, back to RUN.
//  mem_busy held 3 cycles mid-FLUSH -> stall_fd/stall_ex=1 for 3, flush extended by 3.
//  Branch + load-use same cycle -> redirect only, stall_count=0; wb_is_final -> halted=1
//   next cycle, stays 1 for 100 cycles, cleared by rst.
//  Force stall_count to all-ones via 2^CNT_W stalls (CNT_W=4) -> holds 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-controller signals between the pipeline and the controller.
//   master : pipeline side; drives decode/execute/memory/writeback status and
//            receives stall/kill/redirect controls and perf counts.
//   slave  : hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_write_to_rd;
  logic             mem_valid;
  logic             mem_is_branch;
  logic [63:0]      mem_branch_target;
  logic             mem_busy;
  logic             wb_valid;
  logic             wb_is_final;
  logic             stall_fd;
  logic             stall_ex;
  logic             bubble_ex;
  logic             kill_fd;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_rd, ex_is_load, ex_write_to_rd,
           mem_valid, mem_is_branch, mem_branch_target, mem_busy,
           wb_valid, wb_is_final,
    input  stall_fd, stall_ex, bubble_ex, kill_fd, redirect_valid, redirect_pc,
           halted, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_rd, ex_is_load, ex_write_to_rd,
           mem_valid, mem_is_branch, mem_branch_target, mem_busy,
           wb_valid, wb_is_final,
    output stall_fd, stall_ex, bubble_ex, kill_fd, redirect_valid, redirect_pc,
           halted, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk, rst : clock, synchronous active-high reset
//   hz       : slave side of pipeline_hazard_ctrl_if
//              in : decode operands, execute rd/load info, memory branch/busy,
//                   writeback final-instruction flag
//              out: stall_fd, stall_ex, bubble_ex, kill_fd, redirect_valid/pc,
//                   halted, saturating stall_count / flush_count
// Control outputs are combinational from state + inputs; state, flush counter
// and perf counters are registered.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fctr_q, fctr_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic        stall_fd, stall_ex, bubble_ex, kill_fd, redirect_valid, halted;
  logic [63:0] redirect_pc;
  logic        load_use, branch, src_hit;

  // Decode reads the register a load in execute is about to write; x0 never hazards.
  assign src_hit  = (hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd));
  assign load_use = hz.ex_valid && hz.ex_is_load && hz.ex_write_to_rd &&
                    (hz.ex_rd != 5'd0) && hz.id_valid && src_hit;
  assign branch   = hz.mem_valid && hz.mem_is_branch;

  always_comb begin
    state_d        = state_q;
    fctr_d         = fctr_q;
    stall_fd       = 1'b0;
    stall_ex       = 1'b0;
    bubble_ex      = 1'b0;
    kill_fd        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halted         = 1'b0;
    if (!rst) begin
      if (state_q == HALT) begin
        stall_fd = 1'b1;
        stall_ex = 1'b1;
        halted   = 1'b1;
      end else begin
        if (hz.mem_busy) begin
          // Whole machine holds; flush progress and any pending branch wait.
          stall_fd = 1'b1;
          stall_ex = 1'b1;
        end else if (state_q == FLUSH) begin
          // Branches seen here are wrong-path and already being killed.
          kill_fd   = 1'b1;
          bubble_ex = 1'b1;
          fctr_d    = fctr_q - 1'b1;
          if (fctr_d == '0) state_d = RUN;
        end else if (branch) begin
          redirect_valid = 1'b1;
          redirect_pc    = hz.mem_branch_target;
          kill_fd        = 1'b1;
          bubble_ex      = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fctr_d  = FW'(FLUSH_CYCLES - 1);
          end
        end else if (load_use) begin
          // Load advances while decode holds one cycle; forwarding covers the rest.
          stall_fd  = 1'b1;
          bubble_ex = 1'b1;
        end
        if (hz.wb_valid && hz.wb_is_final) state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fctr_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fctr_q  <= fctr_d;
      if (stall_fd && (state_q != HALT) && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_valid && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_fd       = stall_fd;
  assign hz.stall_ex       = stall_ex;
  assign hz.bubble_ex      = bubble_ex;
  assign hz.kill_fd        = kill_fd;
  assign hz.redirect_valid = redirect_valid;
  assign hz.redirect_pc    = redirect_pc;
  assign hz.halted         = halted;
  assign hz.stall_count    = stall_cnt_q;
  assign hz.flush_count    = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int FC  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic          stall_fd;
    logic          stall_ex;
    logic          bubble_ex;
    logic          kill_fd;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          halted;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;
  } outs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz();
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hz));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: machine-level facts, not an encoding of the RTL.
  bit m_halted;
  int m_flush_left;   // kill cycles still owed after the redirect cycle
  int m_stalls;
  int m_flushes;

  function automatic int sat_inc(int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic outs_t model_eval();
    outs_t e;
    bit    hazard;
    e = '0;
    e.stall_count = CW'(m_stalls);
    e.flush_count = CW'(m_flushes);
    hazard = hz.ex_valid && hz.ex_is_load && hz.ex_write_to_rd && hz.ex_rd != 0 &&
             hz.id_valid && ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
                             (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
    if (rst) return e;
    if (m_halted) begin
      e.stall_fd = 1; e.stall_ex = 1; e.halted = 1;
    end else if (hz.mem_busy) begin
      e.stall_fd = 1; e.stall_ex = 1;
    end else if (m_flush_left > 0) begin
      e.kill_fd = 1; e.bubble_ex = 1;
    end else if (hz.mem_valid && hz.mem_is_branch) begin
      e.redirect_valid = 1; e.redirect_pc = hz.mem_branch_target;
      e.kill_fd = 1; e.bubble_ex = 1;
    end else if (hazard) begin
      e.stall_fd = 1; e.bubble_ex = 1;
    end
    return e;
  endfunction

  task automatic model_commit(input outs_t e);
    if (rst) begin
      m_halted = 0; m_flush_left = 0; m_stalls = 0; m_flushes = 0;
    end else if (!m_halted) begin
      if (e.stall_fd) m_stalls = sat_inc(m_stalls);
      if (e.redirect_valid) begin
        m_flushes    = sat_inc(m_flushes);
        m_flush_left = FC - 1;
      end else if (m_flush_left > 0 && !hz.mem_busy) begin
        m_flush_left--;
      end
      if (hz.wb_valid && hz.wb_is_final) m_halted = 1;
    end
  endtask

  function automatic outs_t obs();
    outs_t o;
    o.stall_fd       = hz.stall_fd;
    o.stall_ex       = hz.stall_ex;
    o.bubble_ex      = hz.bubble_ex;
    o.kill_fd        = hz.kill_fd;
    o.redirect_valid = hz.redirect_valid;
    o.redirect_pc    = hz.redirect_pc;
    o.halted         = hz.halted;
    o.stall_count    = hz.stall_count;
    o.flush_count    = hz.flush_count;
    return o;
  endfunction

  task automatic idle();
    rst = 0;
    hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
    hz.ex_valid = 0; hz.ex_rd = 0; hz.ex_is_load = 0; hz.ex_write_to_rd = 0;
    hz.mem_valid = 0; hz.mem_is_branch = 0; hz.mem_branch_target = '0; hz.mem_busy = 0;
    hz.wb_valid = 0; hz.wb_is_final = 0;
  endtask

  task automatic randomize_inputs(input int busy_pct, input int br_pct, input int fin_pct);
    hz.id_valid    = 1'($urandom_range(0, 3) != 0);
    hz.id_rs1      = 5'($urandom_range(0, 3));
    hz.id_rs2      = 5'($urandom_range(0, 3));
    hz.id_uses_rs1 = 1'($urandom);
    hz.id_uses_rs2 = 1'($urandom);
    hz.ex_valid    = 1'($urandom_range(0, 3) != 0);
    hz.ex_rd       = 5'($urandom_range(0, 3));
    hz.ex_is_load  = 1'($urandom);
    hz.ex_write_to_rd = 1'($urandom_range(0, 3) != 0);
    hz.mem_valid   = 1'($urandom);
    hz.mem_is_branch = 1'($urandom_range(0, 99) < br_pct);
    hz.mem_branch_target = {$urandom, $urandom};
    hz.mem_busy    = 1'($urandom_range(0, 99) < busy_pct);
    hz.wb_valid    = 1'($urandom);
    hz.wb_is_final = 1'($urandom_range(0, 99) < fin_pct);
  endtask

  task automatic load_use_inputs(input logic [4:0] rd, input logic uses2);
    hz.ex_valid = 1; hz.ex_is_load = 1; hz.ex_write_to_rd = 1; hz.ex_rd = rd;
    hz.id_valid = 1; hz.id_rs2 = 5'd5; hz.id_uses_rs2 = uses2;
    hz.id_rs1 = 5'd9; hz.id_uses_rs1 = 1;
  endtask

  task automatic test_reset();
    outs_t e;
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 3) begin randomize_inputs(20, 40, 10); rst = 1; end
      #1; e = model_eval(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset c=%0d got=%h exp=%h", c, obs(), e);
      end
      model_commit(e); @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    outs_t e;
    logic [4:0] rd_tab [3] = '{5'd5, 5'd0, 5'd5};
    logic       u2_tab [3] = '{1'b1, 1'b1, 1'b0};
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        idle();
        if (c == 0) rst = 1;
        if (c == 1) begin
          load_use_inputs(rd_tab[p], u2_tab[p]);
          if (rd_tab[p] == 0) hz.id_rs2 = 5'd0;
        end
        #1; e = model_eval(); vectors++;
        if (obs() !== e) begin
          miscompares++;
          $display("FAIL load_use p=%0d c=%0d got=%h exp=%h", p, c, obs(), e);
        end
        model_commit(e); @(negedge clk);
      end
    end
  endtask

  task automatic test_branch();
    outs_t e;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) rst = 1;
      if (c == 1 || c == 2) begin
        hz.mem_valid = 1; hz.mem_is_branch = 1;
        hz.mem_branch_target = (c == 1) ? 64'h0000_0000_8000_0040 : 64'h1234;
      end
      #1; e = model_eval(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL branch c=%0d got=%h exp=%h", c, obs(), e);
      end
      model_commit(e); @(negedge clk);
    end
  endtask

  task automatic test_busy_flush();
    outs_t e;
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) rst = 1;
      if (c == 1) begin
        hz.mem_valid = 1; hz.mem_is_branch = 1; hz.mem_branch_target = 64'hdead_beef_0000_0100;
      end
      if (c >= 2 && c <= 4) hz.mem_busy = 1;
      if (c == 3) begin hz.mem_valid = 1; hz.mem_is_branch = 1; end
      #1; e = model_eval(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL busy_flush c=%0d got=%h exp=%h", c, obs(), e);
      end
      model_commit(e); @(negedge clk);
    end
  endtask

  task automatic test_branch_loaduse_halt();
    outs_t e;
    for (int c = 0; c < 110; c++) begin
      idle();
      if (c == 0 || c == 108) rst = 1;
      if (c == 1) begin
        load_use_inputs(5'd5, 1'b1);
        hz.mem_valid = 1; hz.mem_is_branch = 1; hz.mem_branch_target = 64'h40;
      end
      if (c == 4) begin hz.wb_valid = 1; hz.wb_is_final = 1; end
      if (c > 4 && c < 108) randomize_inputs(20, 30, 5);
      #1; e = model_eval(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL branch_lu_halt c=%0d got=%h exp=%h", c, obs(), e);
      end
      model_commit(e); @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    outs_t e;
    for (int c = 0; c < 2 + (1 << CW) + 4; c++) begin
      idle();
      if (c == 0) rst = 1;
      else load_use_inputs(5'd5, 1'b1);
      #1; e = model_eval(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL saturate c=%0d got=%h exp=%h", c, obs(), e);
      end
      model_commit(e); @(negedge clk);
    end
  endtask

  task automatic test_random();
    outs_t e;
    for (int c = 0; c < 3000; c++) begin
      idle();
      randomize_inputs(15, 15, 2);
      rst = ($urandom_range(0, 59) == 0);
      #1; e = model_eval(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs(), e);
      end
      model_commit(e); @(negedge clk);
    end
  endtask

  initial begin
    m_halted = 0; m_flush_left = 0; m_stalls = 0; m_flushes = 0;
    idle();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_busy_flush();
    test_branch_loaduse_halt();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
